// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor port scheduler: queue entries and port ownership.
package bp_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } iq_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } uq_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        UPDATE
    } port_owner_e;

endpackage

// File: rtl/bp_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head, clear, and push-while-full when popping.
module bp_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bp_port_scheduler.sv
// Arbitrates the predictor's single port between fetch lookups and execute updates,
// tracks in-flight predictions and raises a registered redirect on mispredict.
module bp_port_scheduler
    import bp_pkg::*;
#(
    parameter int unsigned IQ_DEPTH = 4,
    parameter int unsigned UQ_DEPTH = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_valid,
    input  logic [31:0]      f_pc,
    input  logic             f_is_branch,
    output logic             f_stall,
    output logic             f_pred_taken,
    output logic [31:0]      f_pred_target,
    output logic [31:0]      bp_addr,
    output logic             bp_update,
    output logic             bp_taken,
    output logic [31:0]      bp_target,
    input  logic             bp_pred_taken,
    input  logic [31:0]      bp_pred_addr,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam int unsigned IQ_W = $bits(iq_entry_t);
    localparam int unsigned UQ_W = $bits(uq_entry_t);

    port_owner_e owner;
    iq_entry_t   iq_head;
    iq_entry_t   iq_push_data;
    uq_entry_t   uq_head;
    uq_entry_t   uq_push_data;
    logic        iq_full, iq_empty, uq_full, uq_empty;
    logic        lookup_req, lookup_grant, head_match, mispredict;
    logic [31:0] bp_addr_q;

    assign lookup_req = f_valid & f_is_branch;

    always_comb begin
        owner = IDLE;
        if (uq_full || (!uq_empty && !lookup_req)) owner = UPDATE;
        else if (lookup_req)                       owner = LOOKUP;
    end

    assign head_match = ex_valid && !iq_empty && (iq_head.pc == ex_pc);
    assign mispredict = head_match &&
                        ((iq_head.taken != ex_taken) ||
                         (ex_taken && (iq_head.target != ex_target)));

    // A resolving pop frees a slot for the lookup pushed on the same edge.
    assign lookup_grant  = (owner == LOOKUP) && !redirect && (!iq_full || head_match);
    assign f_stall       = lookup_req && !lookup_grant;
    assign f_pred_taken  = lookup_grant ? bp_pred_taken : 1'b0;
    assign f_pred_target = lookup_grant ? bp_pred_addr : '0;

    assign bp_update = (owner == UPDATE);
    assign bp_taken  = bp_update ? uq_head.taken : 1'b0;
    assign bp_target = bp_update ? uq_head.target : '0;

    always_comb begin
        bp_addr = bp_addr_q;
        if (bp_update)         bp_addr = uq_head.pc;
        else if (lookup_grant) bp_addr = f_pc;
    end

    assign iq_push_data = '{pc: f_pc, taken: bp_pred_taken, target: bp_pred_addr};
    assign uq_push_data = '{pc: ex_pc, taken: ex_taken, target: ex_target};

    bp_sync_fifo #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (IQ_W)
    ) u_iq (
        .clk       (clk),
        .reset     (reset),
        .push      (lookup_grant),
        .push_data (iq_push_data),
        .pop       (head_match),
        .clear     (mispredict),
        .head      (iq_head),
        .full      (iq_full),
        .empty     (iq_empty)
    );

    bp_sync_fifo #(
        .DEPTH (UQ_DEPTH),
        .WIDTH (UQ_W)
    ) u_uq (
        .clk       (clk),
        .reset     (reset),
        .push      (ex_valid),
        .push_data (uq_push_data),
        .pop       (bp_update),
        .clear     (1'b0),
        .head      (uq_head),
        .full      (uq_full),
        .empty     (uq_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_addr_q    <= '0;
            redirect     <= 1'b0;
            redirect_pc  <= '0;
            cnt_branches <= '0;
            cnt_mispred  <= '0;
        end else begin
            bp_addr_q <= bp_addr;
            redirect  <= mispredict;
            if (mispredict) redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
            if (ex_valid && (cnt_branches != '1)) cnt_branches <= cnt_branches + 1'b1;
            if (mispredict && (cnt_mispred != '1)) cnt_mispred <= cnt_mispred + 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_port_scheduler.sv
// Directed bench for bp_port_scheduler with hand-computed expectations.
module tb_bp_port_scheduler;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             f_valid;
    logic [31:0]      f_pc;
    logic             f_is_branch;
    logic             f_stall;
    logic             f_pred_taken;
    logic [31:0]      f_pred_target;
    logic [31:0]      bp_addr;
    logic             bp_update;
    logic             bp_taken;
    logic [31:0]      bp_target;
    logic             bp_pred_taken;
    logic [31:0]      bp_pred_addr;
    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] cnt_branches;
    logic [CNT_W-1:0] cnt_mispred;

    int checks = 0;
    int errors = 0;

    bp_port_scheduler #(
        .IQ_DEPTH (4),
        .UQ_DEPTH (2),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .f_valid       (f_valid),
        .f_pc          (f_pc),
        .f_is_branch   (f_is_branch),
        .f_stall       (f_stall),
        .f_pred_taken  (f_pred_taken),
        .f_pred_target (f_pred_target),
        .bp_addr       (bp_addr),
        .bp_update     (bp_update),
        .bp_taken      (bp_taken),
        .bp_target     (bp_target),
        .bp_pred_taken (bp_pred_taken),
        .bp_pred_addr  (bp_pred_addr),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .cnt_branches  (cnt_branches),
        .cnt_mispred   (cnt_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic ptaken, input logic [31:0] paddr);
        f_valid       = 1'b1;
        f_is_branch   = 1'b1;
        f_pc          = pc;
        bp_pred_taken = ptaken;
        bp_pred_addr  = paddr;
    endtask

    task automatic idle_fetch();
        f_valid       = 1'b0;
        f_is_branch   = 1'b0;
        bp_pred_taken = 1'b0;
        bp_pred_addr  = '0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        ex_valid  = 1'b1;
        ex_pc     = pc;
        ex_taken  = taken;
        ex_target = target;
    endtask

    task automatic idle_ex();
        ex_valid  = 1'b0;
        ex_taken  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        f_pc = '0;
        ex_pc = '0;
        ex_target = '0;
        idle_fetch();
        idle_ex();
        #3;
        check("rst_redirect", redirect, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_bp_update", bp_update, 0);
        check("rst_bp_addr", bp_addr, 0);
        check("rst_cnt_br", cnt_branches, 0);
        check("rst_cnt_mp", cnt_mispred, 0);
        check("rst_f_stall", f_stall, 0);
        reset = 1'b0;
        tick();

        // Lookup 0x100 predicted not-taken
        fetch(32'h100, 1'b0, 32'h0);
        #1;
        check("t1_stall", f_stall, 0);
        check("t1_pred_taken", f_pred_taken, 0);
        check("t1_bp_addr", bp_addr, 32'h100);
        check("t1_bp_update", bp_update, 0);
        tick();
        idle_fetch();
        f_valid = 1'b1;
        f_pc    = 32'h104;
        #1;
        check("t1_nonbranch_stall", f_stall, 0);
        check("t1_addr_hold", bp_addr, 32'h100);
        idle_fetch();

        // Resolve taken to 0x200: mispredict
        resolve(32'h100, 1'b1, 32'h200);
        #1;
        check("t2_redirect_early", redirect, 0);
        tick();
        idle_ex();
        fetch(32'h500, 1'b0, 32'h0);
        #1;
        check("t2_redirect", redirect, 1);
        check("t2_redirect_pc", redirect_pc, 32'h200);
        check("t2_lookup_blocked", f_stall, 1);
        check("t2_no_update", bp_update, 0);
        check("t2_cnt_br", cnt_branches, 1);
        check("t2_cnt_mp", cnt_mispred, 1);
        tick();
        idle_fetch();
        #1;
        check("t2_redirect_pulse", redirect, 0);
        check("t2_update", bp_update, 1);
        check("t2_upd_addr", bp_addr, 32'h100);
        check("t2_upd_taken", bp_taken, 1);
        check("t2_upd_target", bp_target, 32'h200);
        tick();
        #1;
        check("t2_uq_drained", bp_update, 0);
        check("t2_addr_hold", bp_addr, 32'h100);

        // IQ was cleared: resolving 0x100 again matches nothing
        resolve(32'h100, 1'b1, 32'h200);
        tick();
        idle_ex();
        #1;
        check("t2_empty_no_redirect", redirect, 0);
        check("t2_empty_cnt_br", cnt_branches, 2);
        check("t2_empty_cnt_mp", cnt_mispred, 1);
        check("t2_empty_uq_push", bp_update, 1);
        tick();

        // Predicted taken, resolved not-taken
        fetch(32'h104, 1'b1, 32'h300);
        #1;
        check("t3_pred_taken", f_pred_taken, 1);
        check("t3_pred_target", f_pred_target, 32'h300);
        tick();
        idle_fetch();
        resolve(32'h104, 1'b0, 32'h300);
        tick();
        idle_ex();
        #1;
        check("t3_nt_redirect", redirect, 1);
        check("t3_nt_redirect_pc", redirect_pc, 32'h108);
        check("t3_nt_cnt_mp", cnt_mispred, 2);
        tick();

        // Wrong target
        fetch(32'h110, 1'b1, 32'h300);
        #1;
        check("t3_tgt_grant", f_stall, 0);
        tick();
        idle_fetch();
        resolve(32'h110, 1'b1, 32'h340);
        tick();
        idle_ex();
        #1;
        check("t3_tgt_redirect", redirect, 1);
        check("t3_tgt_redirect_pc", redirect_pc, 32'h340);
        check("t3_tgt_cnt_br", cnt_branches, 4);
        check("t3_tgt_cnt_mp", cnt_mispred, 3);
        tick();

        // Correct prediction: no redirect
        fetch(32'h120, 1'b1, 32'h400);
        tick();
        idle_fetch();
        resolve(32'h120, 1'b1, 32'h400);
        tick();
        idle_ex();
        #1;
        check("t3_ok_redirect", redirect, 0);
        check("t3_ok_redirect_pc", redirect_pc, 32'h340);
        check("t3_ok_cnt_br", cnt_branches, 5);
        check("t3_ok_cnt_mp", cnt_mispred, 3);
        tick();

        // Back-to-back lookups with resolutions filling the UQ
        fetch(32'h200, 1'b0, 32'h0);
        tick();
        fetch(32'h204, 1'b0, 32'h0);
        tick();
        fetch(32'h208, 1'b0, 32'h0);
        resolve(32'h200, 1'b0, 32'h204);
        #1;
        check("t4_grant_c", f_stall, 0);
        tick();
        fetch(32'h20C, 1'b0, 32'h0);
        resolve(32'h204, 1'b0, 32'h208);
        #1;
        check("t4_grant_d", f_stall, 0);
        check("t4_grant_d_noupd", bp_update, 0);
        tick();
        idle_ex();
        fetch(32'h210, 1'b0, 32'h0);
        #1;
        check("t4_forced_update", bp_update, 1);
        check("t4_forced_stall", f_stall, 1);
        check("t4_forced_addr", bp_addr, 32'h200);
        check("t4_forced_taken", bp_taken, 0);
        tick();
        #1;
        check("t4_retry_stall", f_stall, 0);
        check("t4_retry_noupd", bp_update, 0);
        check("t4_retry_addr", bp_addr, 32'h210);
        tick();

        // Fill the IQ, then fifth lookup
        fetch(32'h214, 1'b0, 32'h0);
        #1;
        check("t5_fourth_grant", f_stall, 0);
        tick();
        fetch(32'h218, 1'b0, 32'h0);
        #1;
        check("t5_full_stall", f_stall, 1);
        check("t5_full_addr_hold", bp_addr, 32'h214);
        check("t5_full_noupd", bp_update, 0);
        resolve(32'h208, 1'b0, 32'h20C);
        #1;
        check("t5_pop_accept", f_stall, 0);
        check("t5_pop_addr", bp_addr, 32'h218);
        tick();
        idle_fetch();
        resolve(32'h20C, 1'b0, 32'h210);
        #1;
        check("t5_uq_full_update", bp_update, 1);
        check("t5_uq_full_addr", bp_addr, 32'h204);
        tick();
        idle_ex();
        #1;
        check("t5_cnt_br", cnt_branches, 9);
        check("t5_cnt_mp", cnt_mispred, 3);
        check("t6_pre_update", bp_update, 1);

        // Reset with UQ=2 and IQ=3
        reset = 1'b1;
        #1;
        check("t6_rst_update", bp_update, 0);
        check("t6_rst_addr", bp_addr, 0);
        check("t6_rst_redirect_pc", redirect_pc, 0);
        check("t6_rst_cnt_br", cnt_branches, 0);
        check("t6_rst_cnt_mp", cnt_mispred, 0);
        check("t6_rst_redirect", redirect, 0);
        reset = 1'b0;
        tick();
        #1;
        check("t6_post_update_a", bp_update, 0);
        tick();
        #1;
        check("t6_post_update_b", bp_update, 0);
        resolve(32'h210, 1'b1, 32'h999);
        tick();
        idle_ex();
        #1;
        check("t6_iq_gone", redirect, 0);
        check("t6_cnt_br", cnt_branches, 1);
        tick();

        // Branch counter saturation
        for (int i = 0; i < 16; i++) begin
            resolve(32'h900, 1'b0, 32'h0);
            tick();
        end
        idle_ex();
        #1;
        check("sat_cnt_br", cnt_branches, 32'hF);
        tick();

        // Mispredict counter saturation
        for (int i = 0; i < 16; i++) begin
            fetch(32'h600, 1'b0, 32'h0);
            tick();
            idle_fetch();
            resolve(32'h600, 1'b1, 32'h700);
            tick();
            idle_ex();
            tick();
        end
        #1;
        check("sat_cnt_mp", cnt_mispred, 32'hF);
        check("sat_cnt_br_hold", cnt_branches, 32'hF);
        check("sat_redirect_pc", redirect_pc, 32'h700);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
